decoder_arbiter: RTL
====================

# decoder_arbiter

Round-robin arbiter and sequencer that shares the single combinational `decoder_proj` instance among `NREQ` requesters. Each requester presents a 7-bit code with a valid/ready handshake. The arbiter grants one requester, drives the code onto the decoder input, and waits a fixed settle latency. It then captures the decoder output and returns it with the requester ID on a valid/ready response port. The block sits between the user-project I/O front end and the decoder datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `CODE_W`, 7: decoder input width.
- `OUT_W`, 8: decoder output width.
- `DEC_LAT`, 1: settle cycles between driving `dec_in` and sampling `dec_out`, 1..15.
- `IDLE_CODE`, 7'h00: value driven on `dec_in` when no grant is active.
- `TIMEOUT`, 64: response-stall limit in cycles; used only with the macro.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, NREQ: request valid, one bit per requester.
- `req_code`, in, NREQ*CODE_W: packed codes; requester i occupies bits `[i*CODE_W +: CODE_W]`.
- `req_ready`, out, NREQ: one-hot acceptance, combinational from state and grant.
- `dec_in`, out, CODE_W: registered drive to the decoder input.
- `dec_out`, in, OUT_W: decoder result.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response accept.
- `rsp_data`, out, OUT_W: captured decoder output.
- `rsp_id`, out, $clog2(NREQ): ID of the granted requester.
- `err_timeout`, out, 1: sticky timeout flag; present only with the macro.

## Operation
- FSM states: IDLE, SETTLE, RESPOND.
- **IDLE**
  - If any `req_valid` bit is set, pick the first set bit at or after `rr_ptr` (wrapping modulo NREQ).
  - Assert `req_ready` for that bit only in the same cycle.
  - On the clock edge: latch the code into `dec_in`, latch the ID, load the settle counter with `DEC_LAT-1`, and go to SETTLE.
- **SETTLE**
  - Decrement the counter each cycle.
  - When the counter is 0: register `dec_out` into `rsp_data`, set `rsp_valid`, go to RESPOND.
- **RESPOND**
  - Hold `rsp_valid`, `rsp_data`, `rsp_id`, and `dec_in` stable until `rsp_ready`.
  - On handshake: clear `rsp_valid`, set `rr_ptr` to granted ID + 1 (wrapping NREQ-1 to 0), drive `dec_in` to `IDLE_CODE`, go to IDLE.
- `req_ready` is all-zero outside IDLE, so exactly one request is in flight.
- Requester-side rule: a requester must hold `req_valid` and `req_code` stable until it sees `req_ready`.
- Starvation-free: a continuously valid requester is served within NREQ grants.
- Reset values: state IDLE, `rr_ptr` 0, `dec_in` = `IDLE_CODE`, `rsp_valid` 0, `rsp_data` 0, `rsp_id` 0, `req_ready` 0, `err_timeout` 0.
- Reset asserted mid-transaction aborts it; no response is produced for the aborted request.

## Timing
- Request accepted at edge T → `dec_in` valid from T.
- `dec_out` sampled at edge T+DEC_LAT → `rsp_valid` high from T+DEC_LAT.
- Minimum request-to-request throughput: DEC_LAT+2 cycles, when `rsp_ready` is tied high.
- A new grant can be issued in the cycle after the response handshake; there is no combinational path from `rsp_ready` to `req_ready`.
- `dec_out` is assumed purely combinational from `dec_in`. `DEC_LAT` absorbs any pipelining in the decoder.

## Configuration
- `DECODER_ARB_TIMEOUT_EN` defined:
  - A stall counter runs while in RESPOND with `rsp_ready` low.
  - When it reaches `TIMEOUT`, the response is dropped: `rsp_valid` cleared, `rr_ptr` advanced, return to IDLE.
  - `err_timeout` is set and stays set until reset.
- `DECODER_ARB_TIMEOUT_EN` undefined:
  - No counter and no `err_timeout` port.
  - RESPOND waits indefinitely.

## Structure
- Shared package `decoder_arb_pkg`:
  - State enum `arb_state_t` (IDLE, SETTLE, RESPOND).
  - `IDLE_CODE` default.
  - Helper `ID_W(n) = $clog2(n)`.
- One sub-module: `rr_pick`.
  - Combinational rotate-priority encoder.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: `grant_onehot`, `grant_id`, `any`.
- Remaining logic (FSM, counters, registers) lives in `decoder_arbiter`.

## Test plan
- Single request, rsp_ready high:
  - Stimulus: after reset, requester 2 sends 7'h7E with DEC_LAT=1.
  - Response: `req_ready[2]` pulses in cycle 0; `rsp_valid` is high in cycle 1 with `rsp_id`=2 and `rsp_data` equal to the decoder output for 7'h7E.
  - After the handshake, `dec_in` returns to `IDLE_CODE`.
- All four requesters valid continuously:
  - Grant order is 0,1,2,3,0.
  - Each transaction takes DEC_LAT+2 cycles.
- Backpressure:
  - Stimulus: hold `rsp_ready` low for 10 cycles.
  - Response: `rsp_data`, `rsp_id`, and `dec_in` stay stable and `req_ready` stays 0 throughout; the transaction completes on the first `rsp_ready` high.
- Wrap-around:
  - Stimulus: only requesters 3 and 0 valid, with `rr_ptr`=3.
  - Response: grants 3 then 0, then 3 again.
- Reset mid-SETTLE with DEC_LAT=4:
  - Stimulus: assert `reset` in the 2nd settle cycle.
  - Response: next cycle is IDLE, `rsp_valid` is 0, and `dec_in` = `IDLE_CODE`; no response is emitted afterwards.
- Timeout (macro on, TIMEOUT=8):
  - Stimulus: hold `rsp_ready` low.
  - Response: `rsp_valid` drops after 8 stall cycles, `err_timeout` becomes 1 and stays 1, and the next requester is granted.

Source files
------------

// File: rtl/decoder_arb_pkg.sv
// Shared definitions for the decoder arbiter slice.
//   arb_state_t       : sequencer states (IDLE, SETTLE, RESPOND)
//   IDLE_CODE_DEFAULT : code driven onto the decoder when nothing is granted
//   ID_W(n)           : width of a requester ID for n requesters
package decoder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESPOND
  } arb_state_t;

  localparam logic [6:0] IDLE_CODE_DEFAULT = 7'h00;

  function automatic int ID_W(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/decoder_arbiter_rr_pick.sv
// Rotate-priority encoder: finds the first set request bit at or after
// ptr, wrapping modulo NREQ.
// Ports:
//   req          in  NREQ  request bits
//   ptr          in  ID_W  position with highest priority
//   grant_onehot out NREQ  one-hot winner (zero when nothing requested)
//   grant_id     out ID_W  index of the winner
//   any          out 1     at least one request present
module rr_pick
  import decoder_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]       req,
  input  logic [ID_W(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]       grant_onehot,
  output logic [ID_W(NREQ)-1:0] grant_id,
  output logic                  any
);

  localparam int IDW = ID_W(NREQ);

  // ptr + k folded back into 0..NREQ-1; NREQ need not be a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan from the farthest offset down to the nearest so the nearest set
  // bit (lowest offset from ptr) is the last one written and wins.
  always_comb begin
    grant_id = '0;
    any      = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        grant_id = wrap_add(ptr, k);
        any      = 1'b1;
      end
    end
    grant_onehot = any ? (NREQ'(1) << grant_id) : '0;
  end

endmodule

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational decoder among
// NREQ requesters. One request is in flight at a time: grant, drive the
// code onto dec_in, wait DEC_LAT cycles, capture dec_out, then hold the
// response until it is accepted.
// Optional feature macro: DECODER_ARB_TIMEOUT_EN adds a response-stall
// timeout (parameter TIMEOUT) and the sticky err_timeout output.
// Ports:
//   clock, reset  in   clock, synchronous active-high reset
//   req_valid     in   NREQ         request valid per requester
//   req_code      in   NREQ*CODE_W  packed request codes
//   req_ready     out  NREQ         one-hot acceptance (IDLE only)
//   dec_in        out  CODE_W       registered decoder input
//   dec_out       in   OUT_W        decoder result
//   rsp_valid     out  1            response valid
//   rsp_ready     in   1            response accept
//   rsp_data      out  OUT_W        captured decoder output
//   rsp_id        out  ID_W         granted requester ID
//   err_timeout   out  1            sticky timeout flag (macro only)
module decoder_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int CODE_W  = 7,
  parameter int OUT_W   = 8,
  parameter int DEC_LAT = 1,
`ifdef DECODER_ARB_TIMEOUT_EN
  parameter int TIMEOUT = 64,
`endif
  parameter logic [CODE_W-1:0] IDLE_CODE = CODE_W'(IDLE_CODE_DEFAULT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CODE_W-1:0]   req_code,
  output logic [NREQ-1:0]          req_ready,
  output logic [CODE_W-1:0]        dec_in,
  input  logic [OUT_W-1:0]         dec_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [OUT_W-1:0]         rsp_data,
`ifdef DECODER_ARB_TIMEOUT_EN
  output logic                     err_timeout,
`endif
  output logic [ID_W(NREQ)-1:0]    rsp_id
);

  localparam int IDW = ID_W(NREQ);
  localparam logic [3:0] SETTLE_LOAD = 4'(DEC_LAT - 1);

  arb_state_t        state;
  logic [IDW-1:0]    rr_ptr;
  logic [3:0]        settle_cnt;
  logic [NREQ-1:0]   grant_onehot;
  logic [IDW-1:0]    grant_id;
  logic              grant_any;
  logic [CODE_W-1:0] sel_code;
  logic [IDW-1:0]    next_ptr;

`ifdef DECODER_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_id     (grant_id),
    .any          (grant_any)
  );

  // Acceptance only while idle; held low during reset so a requester never
  // sees an acceptance that the reset is about to discard.
  assign req_ready = (state == IDLE && !reset) ? grant_onehot : '0;

  always_comb begin
    sel_code = req_code[int'(grant_id)*CODE_W +: CODE_W];
  end

  // rsp_id holds the granted ID for the whole transaction, so the next
  // round-robin position is derived from it.
  assign next_ptr = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);

  // Sequencer: grant, settle, respond. All outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      dec_in     <= IDLE_CODE;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      settle_cnt <= '0;
`ifdef DECODER_ARB_TIMEOUT_EN
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            dec_in     <= sel_code;
            rsp_id     <= grant_id;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            rsp_data  <= dec_out;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
`ifdef DECODER_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            dec_in    <= IDLE_CODE;
            state     <= IDLE;
          end
`ifdef DECODER_ARB_TIMEOUT_EN
          // A response stalled for TIMEOUT cycles is dropped so the other
          // requesters are not locked out by a dead consumer.
          else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
            rsp_valid   <= 1'b0;
            rr_ptr      <= next_ptr;
            dec_in      <= IDLE_CODE;
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
